rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
- Parametrised reorder buffer: the next generation of the single-slot-type ROB built on rob_entry_t.
- Allocates up to N_INS slots per cycle in program order at dispatch and accepts N_WB out-of-order result writebacks.
- Retires up to N_COMMIT consecutive completed head entries per cycle to the register file.
- Provides N_RD operand-forwarding read ports (feeding fwd_info_t-style lookups).
- Sits between decode/issue-queue dispatch and register-file writeback; supports full pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of 2, at least 4.
- N_INS, 2, dispatch (insert) lanes per cycle.
- N_WB, 2, writeback ports.
- N_COMMIT, 2, commit lanes per cycle.
- N_RD, 4, forwarding read ports.
- SW, $clog2(DEPTH), slot index width (derived).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries this cycle
- ins_valid  in  N_INS  per-lane allocate request
- ins_dest_reg  in  N_INS*5  destination register per lane
- ins_dest_valid  in  N_INS  lane writes a register
- ins_ready  out  1  at least N_INS entries free
- ins_slot  out  N_INS*SW  slot allocated per lane (combinational)
- wb_valid  in  N_WB  writeback strobe
- wb_slot  in  N_WB*SW  target slot
- wb_hi  in  N_WB*32  result_hi
- wb_lo  in  N_WB*32  result_lo
- rd_slot  in  N_RD*SW  forwarding lookup slot
- rd_ready  out  N_RD  result available
- rd_hi  out  N_RD*32  forwarded hi
- rd_lo  out  N_RD*32  forwarded lo
- commit_valid  out  N_COMMIT  lane retiring this cycle
- commit_dest_reg  out  N_COMMIT*5  destination register
- commit_dest_valid  out  N_COMMIT  register write enable
- commit_lo  out  N_COMMIT*32  value to write
- commit_hi  out  N_COMMIT*32  hi value (mult/div)
- count  out  SW+1  occupied entries

Behaviour:
- Reset (async, reset_n=0):
  - head=tail=count=0; all valid/done bits cleared.
  - Outputs derived from state are therefore 0; ins_ready=1.
- Entry state per slot: valid, done, dest_reg, dest_valid, hi, lo.
- Insert:
  - Accepted only when ins_ready=1, i.e. DEPTH-count >= N_INS, evaluated on pre-edge count (commits in the same cycle do not free space early).
  - Valid lanes need not be contiguous. Lane i gets slot (tail + popcount(ins_valid[i-1:0])) mod DEPTH; ins_slot is meaningless for invalid lanes.
  - At the edge: entries written with valid=1, done=0; tail advances by popcount(ins_valid).
  - ins_valid while ins_ready=0 is dropped; assertion fires.
- Writeback:
  - Sets done and stores hi/lo at the edge.
  - Writeback to an invalid or already-done slot is illegal (assertion); state is unchanged.
  - Two ports to the same slot in one cycle is illegal; the higher port index wins.
- Commit:
  - Lane k is valid iff count>k, entries head..head+k are all done, and flush=0.
  - Outputs are combinational from registered state. Writeback-to-commit latency is 1 cycle (no bypass).
  - At the edge: committed entries are cleared and head advances by the number of committed lanes.
- Count: next = count + inserted - committed; wrap-around of head/tail is mod DEPTH.
- Forwarding:
  - rd_ready=1 if the slot is done, or if any wb port targets that slot this cycle (same-cycle bypass; highest port wins).
  - Data follows the same priority. An invalid slot returns rd_ready=0.
- Flush:
  - Synchronous, highest priority.
  - At the edge: all valid/done bits are cleared and head=tail=count=0.
  - Inserts and writebacks in the flush cycle are ignored; commit_valid=0 that cycle.
- Empty: commit_valid=0. Full: ins_ready=0; writebacks and commits proceed normally.

Decomposition:
- Shared package pipTypes gains:
  - rob_slot_t sized by the default DEPTH.
  - An extended rob_entry_t with a done bit.
  - ROB_DEPTH_DEFAULT.
- Sub-module rob_prefix_cnt: parametrised prefix popcount, used for insert slot assignment and for the commit run-length of head done bits.

Test Plan:
- Reset then insert lanes {1,1} dest r3,r4 -> ins_slot 0,1; count=2; commit_valid=0 until writeback.
- Writeback slot1 then slot0 (lo=0xAAAA, 0x5555) on the next cycle -> no commit after slot1 alone; the cycle after slot0 wb: commit_valid=2'b11, r3=0x5555, r4=0xAAAA; count=0.
- Fill DEPTH=16 with 8 double inserts -> ins_ready=0 at count 15 and 16; insert with ins_valid=2'b01 at count=14 accepted, at count=15 dropped with assertion.
- Wrap: head=tail=14, insert 4 across wrap -> slots 14,15,0,1; commit all in two cycles in order.
- Forward: rd_slot=5 with wb on slot 5 in the same cycle -> rd_ready=1 with the wb data; the slot before insert -> rd_ready=0.
- Flush with count=9 plus a simultaneous insert and wb -> next cycle count=0, head=tail=0, commit_valid=0; a reset_n pulse mid-operation likewise clears all state.

Source files
------------

// File: rtl/rob_multi_pkg.sv
// ============================================================================
// Module : rob_multi_pkg
// Brief  : Shared reorder-buffer types: slot index, entry record, default depth.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rob_multi_pkg;

    localparam int ROB_DEPTH_DEFAULT = 16;
    localparam int ROB_SW_DEFAULT    = $clog2(ROB_DEPTH_DEFAULT);
    localparam int REG_W             = 5;
    localparam int DATA_W            = 32;

    typedef logic [ROB_SW_DEFAULT-1:0] rob_slot_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  dest_reg;
        logic              dest_valid;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_multi_prefix_cnt.sv
// ============================================================================
// Module : rob_prefix_cnt
// Brief  : Prefix popcount; field i holds popcount(i_bits[i-1:0]), field N the total.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_prefix_cnt #(
    parameter int N = 2,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]         i_bits,
    output logic [(N+1)*W-1:0]   o_prefix
);

    logic [W-1:0] w_acc;

    always_comb begin
        w_acc    = '0;
        o_prefix = '0;
        for (int i = 0; i < N; i++) begin
            o_prefix[i*W +: W] = w_acc;
            w_acc              = w_acc + W'(i_bits[i]);
        end
        o_prefix[N*W +: W] = w_acc;
    end

endmodule

`default_nettype wire

// File: rtl/rob_multi.sv
// ============================================================================
// Module : rob_multi
// Brief  : Multi-lane reorder buffer with in-order dispatch/commit, OoO writeback
//          and operand forwarding with same-cycle writeback bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH_DEFAULT,
    parameter int N_INS    = 2,
    parameter int N_WB     = 2,
    parameter int N_COMMIT = 2,
    parameter int N_RD     = 4,
    parameter int SW       = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic [N_INS-1:0]          i_ins_valid,
    input  logic [N_INS*REG_W-1:0]    i_ins_dest_reg,
    input  logic [N_INS-1:0]          i_ins_dest_valid,
    output logic                      o_ins_ready,
    output logic [N_INS*SW-1:0]       o_ins_slot,
    input  logic [N_WB-1:0]           i_wb_valid,
    input  logic [N_WB*SW-1:0]        i_wb_slot,
    input  logic [N_WB*DATA_W-1:0]    i_wb_hi,
    input  logic [N_WB*DATA_W-1:0]    i_wb_lo,
    input  logic [N_RD*SW-1:0]        i_rd_slot,
    output logic [N_RD-1:0]           o_rd_ready,
    output logic [N_RD*DATA_W-1:0]    o_rd_hi,
    output logic [N_RD*DATA_W-1:0]    o_rd_lo,
    output logic [N_COMMIT-1:0]       o_commit_valid,
    output logic [N_COMMIT*REG_W-1:0] o_commit_dest_reg,
    output logic [N_COMMIT-1:0]       o_commit_dest_valid,
    output logic [N_COMMIT*DATA_W-1:0] o_commit_lo,
    output logic [N_COMMIT*DATA_W-1:0] o_commit_hi,
    output logic [SW:0]               o_count
);

    localparam int          IPW     = $clog2(N_INS + 1);
    localparam int          CPW     = $clog2(N_COMMIT + 1);
    localparam logic [SW:0] c_depth = (SW+1)'(DEPTH);
    localparam logic [SW:0] c_n_ins = (SW+1)'(N_INS);

    rob_entry_t               r_rob [DEPTH];
    logic [SW-1:0]            r_head;
    logic [SW-1:0]            r_tail;
    logic [SW:0]              r_count;

    logic [(N_INS+1)*IPW-1:0]    w_ins_pfx;
    logic [SW-1:0]               w_ins_slot [N_INS];
    logic                        w_ins_fire;
    logic [SW:0]                 w_ins_add;
    logic [N_COMMIT-1:0]         w_cmt_bits;
    logic [(N_COMMIT+1)*CPW-1:0] w_cmt_pfx;
    logic [SW-1:0]               w_cmt_idx [N_COMMIT];
    logic [SW:0]                 w_cmt_num;

    assign o_count     = r_count;
    // Space check uses pre-edge occupancy; same-cycle commits do not free room.
    assign o_ins_ready = (c_depth - r_count) >= c_n_ins;
    assign w_ins_fire  = o_ins_ready && !i_flush;
    assign w_ins_add   = w_ins_fire ? (SW+1)'(w_ins_pfx[N_INS*IPW +: IPW]) : '0;

    rob_prefix_cnt #(.N(N_INS), .W(IPW)) u_ins_pfx (
        .i_bits   (i_ins_valid),
        .o_prefix (w_ins_pfx)
    );

    for (genvar i = 0; i < N_INS; i++) begin : g_ins
        assign w_ins_slot[i]          = r_tail + SW'(w_ins_pfx[i*IPW +: IPW]);
        assign o_ins_slot[i*SW +: SW] = w_ins_slot[i];
    end

    // A commit lane fires only when every entry from head up to it is done.
    rob_prefix_cnt #(.N(N_COMMIT), .W(CPW)) u_cmt_pfx (
        .i_bits   (w_cmt_bits),
        .o_prefix (w_cmt_pfx)
    );

    for (genvar k = 0; k < N_COMMIT; k++) begin : g_commit
        rob_entry_t w_ent;
        assign w_cmt_idx[k]   = r_head + SW'(k);
        assign w_ent          = r_rob[w_cmt_idx[k]];
        assign w_cmt_bits[k]  = (r_count > (SW+1)'(k)) && w_ent.done;
        assign o_commit_valid[k] = !i_flush && (w_cmt_pfx[(k+1)*CPW +: CPW] == CPW'(k + 1));
        assign o_commit_dest_reg[k*REG_W +: REG_W]  = o_commit_valid[k] ? w_ent.dest_reg : '0;
        assign o_commit_dest_valid[k]               = o_commit_valid[k] && w_ent.dest_valid;
        assign o_commit_lo[k*DATA_W +: DATA_W]      = o_commit_valid[k] ? w_ent.lo : '0;
        assign o_commit_hi[k*DATA_W +: DATA_W]      = o_commit_valid[k] ? w_ent.hi : '0;
    end

    always_comb begin
        w_cmt_num = '0;
        for (int k = 0; k < N_COMMIT; k++) begin
            w_cmt_num = w_cmt_num + (SW+1)'(o_commit_valid[k]);
        end
    end

    for (genvar r = 0; r < N_RD; r++) begin : g_rd
        logic [SW-1:0]     w_s;
        rob_entry_t        w_e;
        logic              w_hit;
        logic              w_rdy;
        logic [DATA_W-1:0] w_hi;
        logic [DATA_W-1:0] w_lo;
        always_comb begin
            w_s   = i_rd_slot[r*SW +: SW];
            w_e   = r_rob[w_s];
            w_hit = 1'b0;
            w_hi  = w_e.hi;
            w_lo  = w_e.lo;
            for (int p = 0; p < N_WB; p++) begin
                if (i_wb_valid[p] && (i_wb_slot[p*SW +: SW] == w_s)) begin
                    w_hit = 1'b1;
                    w_hi  = i_wb_hi[p*DATA_W +: DATA_W];
                    w_lo  = i_wb_lo[p*DATA_W +: DATA_W];
                end
            end
            w_rdy = w_e.valid && (w_e.done || w_hit);
        end
        assign o_rd_ready[r]                = w_rdy;
        assign o_rd_hi[r*DATA_W +: DATA_W]  = w_rdy ? w_hi : '0;
        assign o_rd_lo[r*DATA_W +: DATA_W]  = w_rdy ? w_lo : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i].valid <= 1'b0;
                r_rob[i].done  <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < N_COMMIT; k++) begin
                if (o_commit_valid[k]) begin
                    r_rob[w_cmt_idx[k]].valid <= 1'b0;
                    r_rob[w_cmt_idx[k]].done  <= 1'b0;
                end
            end
            if (w_ins_fire) begin
                for (int i = 0; i < N_INS; i++) begin
                    if (i_ins_valid[i]) begin
                        r_rob[w_ins_slot[i]] <= '{valid: 1'b1, done: 1'b0,
                                                  dest_reg: i_ins_dest_reg[i*REG_W +: REG_W],
                                                  dest_valid: i_ins_dest_valid[i],
                                                  hi: '0, lo: '0};
                    end
                end
            end
            // Legality is judged on pre-edge state, so the highest port wins a clash.
            for (int p = 0; p < N_WB; p++) begin
                if (i_wb_valid[p] && r_rob[i_wb_slot[p*SW +: SW]].valid
                                  && !r_rob[i_wb_slot[p*SW +: SW]].done) begin
                    r_rob[i_wb_slot[p*SW +: SW]].done <= 1'b1;
                    r_rob[i_wb_slot[p*SW +: SW]].hi   <= i_wb_hi[p*DATA_W +: DATA_W];
                    r_rob[i_wb_slot[p*SW +: SW]].lo   <= i_wb_lo[p*DATA_W +: DATA_W];
                end
            end
            r_head  <= r_head + SW'(w_cmt_num);
            r_tail  <= r_tail + SW'(w_ins_add);
            r_count <= r_count + w_ins_add - w_cmt_num;
        end
    end

    a_ins_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(!i_flush && (|i_ins_valid) && !o_ins_ready));

    for (genvar p = 0; p < N_WB; p++) begin : g_wb_chk
        a_wb_legal : assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_wb_valid[p] && !i_flush) |->
            (r_rob[i_wb_slot[p*SW +: SW]].valid && !r_rob[i_wb_slot[p*SW +: SW]].done));
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_multi.sv
// ============================================================================
// Module : tb_rob_multi
// Brief  : Directed scenarios plus randomized traffic checked against a slot-array model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int D  = 16;
    localparam int NI = 2;
    localparam int NW = 2;
    localparam int NC = 2;
    localparam int NR = 4;
    localparam int SW = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [NI-1:0]     ins_valid;
    logic [NI*5-1:0]   ins_dest_reg;
    logic [NI-1:0]     ins_dest_valid;
    logic              ins_ready;
    logic [NI*SW-1:0]  ins_slot;
    logic [NW-1:0]     wb_valid;
    logic [NW*SW-1:0]  wb_slot;
    logic [NW*32-1:0]  wb_hi;
    logic [NW*32-1:0]  wb_lo;
    logic [NR*SW-1:0]  rd_slot;
    logic [NR-1:0]     rd_ready;
    logic [NR*32-1:0]  rd_hi;
    logic [NR*32-1:0]  rd_lo;
    logic [NC-1:0]     commit_valid;
    logic [NC*5-1:0]   commit_dest_reg;
    logic [NC-1:0]     commit_dest_valid;
    logic [NC*32-1:0]  commit_lo;
    logic [NC*32-1:0]  commit_hi;
    logic [SW:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per slot plus head/tail/occupancy integers.
    bit          m_valid [D];
    bit          m_done  [D];
    logic [4:0]  m_dest  [D];
    bit          m_dv    [D];
    logic [31:0] m_hi    [D];
    logic [31:0] m_lo    [D];
    int          m_head, m_tail, m_count;

    rob_multi dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_flush             (flush),
        .i_ins_valid         (ins_valid),
        .i_ins_dest_reg      (ins_dest_reg),
        .i_ins_dest_valid    (ins_dest_valid),
        .o_ins_ready         (ins_ready),
        .o_ins_slot          (ins_slot),
        .i_wb_valid          (wb_valid),
        .i_wb_slot           (wb_slot),
        .i_wb_hi             (wb_hi),
        .i_wb_lo             (wb_lo),
        .i_rd_slot           (rd_slot),
        .o_rd_ready          (rd_ready),
        .o_rd_hi             (rd_hi),
        .o_rd_lo             (rd_lo),
        .o_commit_valid      (commit_valid),
        .o_commit_dest_reg   (commit_dest_reg),
        .o_commit_dest_valid (commit_dest_valid),
        .o_commit_lo         (commit_lo),
        .o_commit_hi         (commit_hi),
        .o_count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_dest[i] = '0; m_dv[i] = 0;
            m_hi[i] = '0; m_lo[i] = '0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
    endfunction

    function automatic int model_commit_n();
        int n = 0;
        while (n < NC && n < m_count && m_done[(m_head + n) % D]) n++;
        return n;
    endfunction

    function automatic void model_edge();
        bit pv [D];
        bit pd [D];
        int ncm, nins, s;
        if (flush) begin
            for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_done[i] = 0; end
            m_head = 0; m_tail = 0; m_count = 0;
            return;
        end
        pv = m_valid; pd = m_done;
        ncm = model_commit_n();
        nins = 0;
        if (D - m_count >= NI) begin
            for (int j = 0; j < NI; j++) begin
                if (ins_valid[j]) begin
                    s = (m_tail + nins) % D;
                    m_valid[s] = 1; m_done[s] = 0; m_dest[s] = ins_dest_reg[j*5 +: 5];
                    m_dv[s] = ins_dest_valid[j]; m_hi[s] = '0; m_lo[s] = '0;
                    nins++;
                end
            end
        end
        for (int p = 0; p < NW; p++) begin
            if (wb_valid[p]) begin
                s = int'(wb_slot[p*SW +: SW]);
                if (pv[s] && !pd[s]) begin
                    m_done[s] = 1; m_hi[s] = wb_hi[p*32 +: 32]; m_lo[s] = wb_lo[p*32 +: 32];
                end
            end
        end
        for (int k = 0; k < ncm; k++) begin
            m_valid[(m_head + k) % D] = 0; m_done[(m_head + k) % D] = 0;
        end
        m_head  = (m_head + ncm) % D;
        m_tail  = (m_tail + nins) % D;
        m_count = m_count + nins - ncm;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        flush = 0; ins_valid = '0; wb_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; flush = 0; ins_valid = '0; wb_valid = '0;
        ins_dest_reg = '0; ins_dest_valid = '0; wb_slot = '0; wb_hi = '0; wb_lo = '0;
        #2;
        model_clear();
        rst_n = 1;
    endtask

    task automatic ins2(input logic [4:0] d1, input logic [4:0] d0);
        ins_valid = 2'b11; ins_dest_reg = {d1, d0}; ins_dest_valid = 2'b11;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; ins_valid = '0; wb_valid = '0; ins_dest_reg = '0;
        ins_dest_valid = '0; wb_slot = '0; wb_hi = '0; wb_lo = '0; rd_slot = 16'h3a5c;
        model_clear();
        #13;
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (ins_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", ins_ready); end
        n_checks++; if (commit_valid !== '0) begin n_errors++; $display("FAIL reset_commit got %b want 0", commit_valid); end
        n_checks++; if (rd_ready !== '0) begin n_errors++; $display("FAIL reset_rd got %b want 0", rd_ready); end
        #8 rst_n = 1;
    endtask

    task automatic test_insert_commit();
        do_reset();
        ins_valid = 2'b11; ins_dest_reg = {5'd4, 5'd3}; ins_dest_valid = 2'b11;
        #1;
        n_checks++; if (ins_slot !== 8'h10) begin n_errors++; $display("FAIL ic_slots got %h want 10", ins_slot); end
        tick();
        n_checks++; if (count !== 5'd2) begin n_errors++; $display("FAIL ic_count got %0d want 2", count); end
        n_checks++; if (commit_valid !== 2'b00) begin n_errors++; $display("FAIL ic_nocommit got %b want 00", commit_valid); end
        wb_valid = 2'b01; wb_slot = 8'h01; wb_lo = 64'h0000_AAAA; wb_hi = '0;
        tick();
        n_checks++; if (commit_valid !== 2'b00) begin n_errors++; $display("FAIL ic_slot1_only got %b want 00", commit_valid); end
        wb_valid = 2'b01; wb_slot = 8'h00; wb_lo = 64'h0000_5555;
        tick();
        n_checks++; if (commit_valid !== 2'b11) begin n_errors++; $display("FAIL ic_commit got %b want 11", commit_valid); end
        n_checks++; if (commit_dest_reg !== {5'd4, 5'd3}) begin n_errors++; $display("FAIL ic_dest got %h want 083", commit_dest_reg); end
        n_checks++; if (commit_lo !== 64'h0000_AAAA_0000_5555) begin n_errors++; $display("FAIL ic_lo got %h want 0000aaaa00005555", commit_lo); end
        tick();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL ic_drain got %0d want 0", count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (ins_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready%0d got %b want 1", i, ins_ready); end
            ins2(5'(2*i+1), 5'(2*i));
        end
        n_checks++; if (ins_ready !== 1'b1 || count !== 5'd14) begin n_errors++; $display("FAIL fill_14 got ready=%b count=%0d want 1/14", ins_ready, count); end
        ins_valid = 2'b01; ins_dest_reg = 10'd9; ins_dest_valid = 2'b01;
        tick();
        n_checks++; if (ins_ready !== 1'b0 || count !== 5'd15) begin n_errors++; $display("FAIL fill_15 got ready=%b count=%0d want 0/15", ins_ready, count); end
        flush = 1;
        tick();
        for (int i = 0; i < 8; i++) ins2(5'd1, 5'd2);
        n_checks++; if (ins_ready !== 1'b0 || count !== 5'd16) begin n_errors++; $display("FAIL fill_16 got ready=%b count=%0d want 0/16", ins_ready, count); end
        wb_valid = 2'b01; wb_slot = 8'h00; wb_lo = 64'h1;
        tick();
        n_checks++; if (commit_valid !== 2'b01) begin n_errors++; $display("FAIL full_commit got %b want 01", commit_valid); end
        tick();
        n_checks++; if (count !== 5'd15 || ins_ready !== 1'b0) begin n_errors++; $display("FAIL full_after got count=%0d ready=%b want 15/0", count, ins_ready); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) ins2(5'd7, 5'd6);
        for (int i = 0; i < 7; i++) begin
            wb_valid = 2'b11; wb_slot = {4'(2*i+1), 4'(2*i)};
            tick();
        end
        for (int t = 0; t < 8 && count !== '0; t++) tick();
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL wrap_drain got %0d want 0", count); end
        ins_valid = 2'b11; ins_dest_reg = {5'd21, 5'd20}; ins_dest_valid = 2'b11;
        #1;
        n_checks++; if (ins_slot !== {4'd15, 4'd14}) begin n_errors++; $display("FAIL wrap_slot_a got %h want fe", ins_slot); end
        tick();
        ins_valid = 2'b11; ins_dest_reg = {5'd23, 5'd22}; ins_dest_valid = 2'b11;
        #1;
        n_checks++; if (ins_slot !== {4'd1, 4'd0}) begin n_errors++; $display("FAIL wrap_slot_b got %h want 10", ins_slot); end
        tick();
        wb_valid = 2'b11; wb_slot = {4'd15, 4'd14}; wb_lo = {32'd15, 32'd14}; wb_hi = '0;
        tick();
        wb_valid = 2'b11; wb_slot = {4'd1, 4'd0}; wb_lo = {32'd1, 32'd0};
        #1;
        n_checks++; if (commit_valid !== 2'b11 || commit_dest_reg !== {5'd21, 5'd20}) begin
            n_errors++; $display("FAIL wrap_commit_a got v=%b d=%h want 11/%h", commit_valid, commit_dest_reg, {5'd21, 5'd20}); end
        tick();
        n_checks++; if (commit_valid !== 2'b11 || commit_dest_reg !== {5'd23, 5'd22} || commit_lo !== {32'd1, 32'd0}) begin
            n_errors++; $display("FAIL wrap_commit_b got v=%b d=%h lo=%h want 11/%h/%h", commit_valid, commit_dest_reg, commit_lo, {5'd23, 5'd22}, {32'd1, 32'd0}); end
        tick();
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_forward();
        do_reset();
        rd_slot = {4'd0, 4'd0, 4'd0, 4'd5};
        #1;
        n_checks++; if (rd_ready[0] !== 1'b0) begin n_errors++; $display("FAIL fwd_invalid got %b want 0", rd_ready[0]); end
        for (int i = 0; i < 3; i++) ins2(5'd1, 5'd1);
        wb_valid = 2'b10; wb_slot = {4'd5, 4'd0}; wb_hi = {32'hDEADBEEF, 32'h0}; wb_lo = {32'h12345678, 32'h0};
        rd_slot = {4'd0, 4'd5, 4'd0, 4'd4};
        #1;
        n_checks++; if (rd_ready[2] !== 1'b1 || rd_hi[64 +: 32] !== 32'hDEADBEEF || rd_lo[64 +: 32] !== 32'h12345678) begin
            n_errors++; $display("FAIL fwd_bypass got r=%b hi=%h lo=%h want 1/deadbeef/12345678", rd_ready[2], rd_hi[64 +: 32], rd_lo[64 +: 32]); end
        n_checks++; if (rd_ready[0] !== 1'b0) begin n_errors++; $display("FAIL fwd_pending got %b want 0", rd_ready[0]); end
        tick();
        n_checks++; if (rd_ready[2] !== 1'b1 || rd_lo[64 +: 32] !== 32'h12345678) begin
            n_errors++; $display("FAIL fwd_stored got r=%b lo=%h want 1/12345678", rd_ready[2], rd_lo[64 +: 32]); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) ins2(5'd2, 5'd1);
        ins_valid = 2'b01; ins_dest_reg = 10'd3; ins_dest_valid = 2'b01;
        wb_valid = 2'b01; wb_slot = 8'h00; wb_lo = 64'd77;
        tick();
        n_checks++; if (count !== 5'd9) begin n_errors++; $display("FAIL flush_pre got %0d want 9", count); end
        flush = 1; ins_valid = 2'b11; wb_valid = 2'b01; wb_slot = 8'h01;
        #1;
        n_checks++; if (commit_valid !== 2'b00) begin n_errors++; $display("FAIL flush_commit got %b want 00", commit_valid); end
        tick();
        n_checks++; if (count !== '0 || commit_valid !== 2'b00) begin n_errors++; $display("FAIL flush_post got count=%0d v=%b want 0/00", count, commit_valid); end
        ins_valid = 2'b11; rd_slot = {4'd0, 4'd0, 4'd1, 4'd0};
        #1;
        n_checks++; if (ins_slot !== 8'h10) begin n_errors++; $display("FAIL flush_tail got %h want 10", ins_slot); end
        n_checks++; if (rd_ready[1:0] !== 2'b00) begin n_errors++; $display("FAIL flush_rd got %b want 00", rd_ready[1:0]); end
        ins_valid = '0;
        ins2(5'd1, 5'd1);
        #2 rst_n = 0;
        #1;
        n_checks++; if (count !== '0 || ins_ready !== 1'b1) begin n_errors++; $display("FAIL rst_pulse got count=%0d ready=%b want 0/1", count, ins_ready); end
        model_clear();
        #2 rst_n = 1;
    endtask

    task automatic test_random();
        int s, j, ncm, off;
        bit hit, erdy, found;
        logic [31:0] ehi, elo;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            flush = ($urandom_range(0, 49) == 0);
            ins_valid = (D - m_count >= NI) ? 2'($urandom_range(0, 3)) : 2'b00;
            ins_dest_reg = 10'($urandom); ins_dest_valid = 2'($urandom);
            wb_hi = {$urandom, $urandom}; wb_lo = {$urandom, $urandom};
            rd_slot = 16'($urandom); wb_valid = '0; wb_slot = '0;
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    off = $urandom_range(0, D - 1); found = 0;
                    for (int k = 0; k < D && !found; k++) begin
                        s = (off + k) % D;
                        if (m_valid[s] && !m_done[s] && !(p == 1 && wb_valid[0] && int'(wb_slot[3:0]) == s)) begin
                            found = 1; wb_valid[p] = 1'b1; wb_slot[p*SW +: SW] = 4'(s);
                        end
                    end
                end
            end
            #1;
            n_checks++; if (ins_ready !== (D - m_count >= NI)) begin n_errors++; $display("FAIL rnd_ready c%0d got %b", cyc, ins_ready); end
            n_checks++; if (count !== 5'(m_count)) begin n_errors++; $display("FAIL rnd_count c%0d got %0d want %0d", cyc, count, m_count); end
            j = 0;
            for (int l = 0; l < NI; l++) begin
                if (ins_valid[l]) begin
                    n_checks++; if (ins_slot[l*SW +: SW] !== 4'((m_tail + j) % D)) begin
                        n_errors++; $display("FAIL rnd_slot c%0d lane%0d got %0d want %0d", cyc, l, ins_slot[l*SW +: SW], (m_tail + j) % D); end
                    j++;
                end
            end
            ncm = flush ? 0 : model_commit_n();
            for (int k = 0; k < NC; k++) begin
                n_checks++; if (commit_valid[k] !== (k < ncm)) begin n_errors++; $display("FAIL rnd_cv c%0d lane%0d got %b want %0d", cyc, k, commit_valid[k], k < ncm); end
                if (k < ncm) begin
                    s = (m_head + k) % D;
                    n_checks++; if (commit_dest_reg[k*5 +: 5] !== m_dest[s] || commit_dest_valid[k] !== m_dv[s]
                                    || commit_lo[k*32 +: 32] !== m_lo[s] || commit_hi[k*32 +: 32] !== m_hi[s]) begin
                        n_errors++; $display("FAIL rnd_cdata c%0d lane%0d got d=%0d lo=%h hi=%h want d=%0d lo=%h hi=%h", cyc, k,
                            commit_dest_reg[k*5 +: 5], commit_lo[k*32 +: 32], commit_hi[k*32 +: 32], m_dest[s], m_lo[s], m_hi[s]); end
                end
            end
            for (int r = 0; r < NR; r++) begin
                s = int'(rd_slot[r*SW +: SW]);
                hit = 0; ehi = m_hi[s]; elo = m_lo[s];
                for (int p = 0; p < NW; p++) begin
                    if (wb_valid[p] && int'(wb_slot[p*SW +: SW]) == s) begin
                        hit = 1; ehi = wb_hi[p*32 +: 32]; elo = wb_lo[p*32 +: 32];
                    end
                end
                erdy = m_valid[s] && (m_done[s] || hit);
                if (!erdy) begin ehi = '0; elo = '0; end
                n_checks++; if (rd_ready[r] !== erdy || rd_hi[r*32 +: 32] !== ehi || rd_lo[r*32 +: 32] !== elo) begin
                    n_errors++; $display("FAIL rnd_rd c%0d port%0d got r=%b hi=%h lo=%h want r=%b hi=%h lo=%h", cyc, r,
                        rd_ready[r], rd_hi[r*32 +: 32], rd_lo[r*32 +: 32], erdy, ehi, elo); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_insert_commit();
        test_fill();
        test_wrap();
        test_forward();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
